// File: rtl/seg7_595_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_595_scan_driver : multiplexed N-digit 7-segment driver for a 2x74HC595
// chain. Define SEG7_LEADING_ZERO_BLANK_EN for leading-zero suppression.
// Rev 1.0
// ============================================================================
module seg7_595_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 12500,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    enable,
    output logic                    sclk,
    output logic                    sdata,
    output logic                    rclk,
    output logic                    srclr_n,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        CLEAR    = 3'd0,
        IDLE     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH_HI = 3'd4,
        LATCH_LO = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [3:0]       bit_idx;

    // Snapshot storage is always 8 digits wide so digit_idx indexes it directly.
    logic [31:0] snap_data;
    logic [7:0]  snap_dp;
    logic [7:0]  snap_blank;

    logic [31:0] data_ext;
    logic [7:0]  dp_ext;
    logic [7:0]  blank_ext;
    logic [7:0]  lz_blank;
    logic [3:0]  nibble;
    logic [7:0]  seg;
    logic [7:0]  dsel;
    logic [15:0] word;

    assign data_ext  = 32'(digit_data);
    assign dp_ext    = 8'(dp_in);
    assign blank_ext = 8'(blank_in);
    assign tick      = (tick_cnt == CNT_MAX);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lz_suppress;

    // Walk down from the top digit; the first nonzero nibble or set dp ends suppression.
    always_comb begin
        lz_blank    = '0;
        lz_suppress = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (i < NUM_DIGITS) begin
                if (lz_suppress && (data_ext[4*i +: 4] == 4'd0) && !dp_ext[i]) begin
                    lz_blank[i] = 1'b1;
                end else begin
                    lz_suppress = 1'b0;
                end
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        nibble = snap_data[{digit_idx, 2'b00} +: 4];
        seg    = snap_blank[digit_idx] ? 8'h00 : {snap_dp[digit_idx], hex7(nibble)};
        if (SEG_ACTIVE_LOW) begin
            seg = ~seg;
        end
        for (int k = 0; k < 8; k++) begin
            dsel[k] = ((k < NUM_DIGITS) && (digit_idx == 3'(k))) ^ DIG_ACTIVE_LOW;
        end
        word = {seg, dsel};
    end

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            sclk       <= 1'b0;
            sdata      <= 1'b0;
            rclk       <= 1'b0;
            srclr_n    <= 1'b0;
            digit_idx  <= 3'd0;
            bit_idx    <= 4'd0;
            frame_done <= 1'b0;
            snap_data  <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    CLEAR: begin
                        srclr_n <= 1'b1;
                        state   <= IDLE;
                    end
                    IDLE: begin
                        if (enable) begin
                            snap_data  <= data_ext;
                            snap_dp    <= dp_ext;
                            snap_blank <= blank_ext | lz_blank;
                            digit_idx  <= 3'd0;
                            bit_idx    <= 4'd0;
                            state      <= SHIFT_LO;
                        end
                    end
                    SHIFT_LO: begin
                        sclk  <= 1'b0;
                        sdata <= word[bit_idx];
                        state <= SHIFT_HI;
                    end
                    SHIFT_HI: begin
                        sclk <= 1'b1;
                        if (bit_idx == 4'd15) begin
                            state <= LATCH_HI;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            state   <= SHIFT_LO;
                        end
                    end
                    LATCH_HI: begin
                        sclk  <= 1'b0;
                        rclk  <= 1'b1;
                        state <= LATCH_LO;
                    end
                    LATCH_LO: begin
                        rclk    <= 1'b0;
                        bit_idx <= 4'd0;
                        if (digit_idx != LAST_IDX) begin
                            digit_idx <= digit_idx + 3'd1;
                            state     <= SHIFT_LO;
                        end else begin
                            frame_done <= 1'b1;
                            digit_idx  <= 3'd0;
                            if (enable) begin
                                snap_data  <= data_ext;
                                snap_dp    <= dp_ext;
                                snap_blank <= blank_ext | lz_blank;
                                state      <= SHIFT_LO;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= CLEAR;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_595_scan_driver.sv
`default_nettype none
// Bench for seg7_595_scan_driver: two instances (opposite polarities) in lockstep
// against a tick/position-based reference model plus directed literal checks.
module tb_seg7_595_scan_driver;

    localparam int N   = 4;
    localparam int CD  = 2;
    localparam int FT  = 34 * N;
    localparam int LIM = 3000;

    logic clk = 1'b0;
    logic rst;
    logic [4*N-1:0] digit_data;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   blank_in;
    logic           enable;

    logic sclk_a, sdata_a, rclk_a, srclr_a, fd_a;
    logic sclk_b, sdata_b, rclk_b, srclr_b, fd_b;
    logic [2:0] idx_a, idx_b;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg7_595_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .digit_data(digit_data), .dp_in(dp_in), .blank_in(blank_in),
        .enable(enable), .sclk(sclk_a), .sdata(sdata_a), .rclk(rclk_a), .srclr_n(srclr_a),
        .digit_idx(idx_a), .frame_done(fd_a));

    seg7_595_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .digit_data(digit_data), .dp_in(dp_in), .blank_in(blank_in),
        .enable(enable), .sclk(sclk_b), .sdata(sdata_b), .rclk(rclk_b), .srclr_n(srclr_b),
        .digit_idx(idx_b), .frame_done(fd_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] m_val [N];
    bit         m_dp  [N];
    bit         m_bl  [N];
    int  m_cnt, m_phase, m_pos, d, q;
    logic m_sclk, m_sda, m_sdb, m_rclk, m_srclr, m_fd;
    logic [2:0] m_idx;
    logic [15:0] wa, wb;
    bit mvalid = 1'b0;

    task automatic take_snap();
        bit sup;
        for (int i = 0; i < N; i++) begin
            m_val[i] = digit_data[4*i +: 4];
            m_dp[i]  = dp_in[i];
            m_bl[i]  = blank_in[i];
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sup = 1'b1;
        for (int i = N - 1; i >= 1; i--) begin
            if (sup && m_val[i] == 4'd0 && !m_dp[i]) m_bl[i] = 1'b1;
            else sup = 1'b0;
        end
`else
        sup = 1'b0;
`endif
    endtask

    function automatic logic [15:0] mword(input int dg, input bit seg_al, input bit dig_al);
        logic [7:0] seg, dsel;
        seg = m_bl[dg] ? 8'h00 : {m_dp[dg], HEX[m_val[dg]]};
        if (seg_al) seg = ~seg;
        dsel = dig_al ? 8'hFF : 8'h00;
        dsel[dg] = ~dsel[dg];
        return {seg, dsel};
    endfunction

    // Each tick advances one position in a 34*N-tick frame: 32 shift half-periods, latch high, latch low.
    always @(posedge clk) begin
        m_fd = 1'b0;
        if (rst) begin
            m_cnt = 0; m_phase = 0; m_pos = 0;
            m_sclk = 0; m_sda = 0; m_sdb = 0; m_rclk = 0; m_srclr = 0; m_idx = 3'd0;
            mvalid = 1'b1;
        end else if (m_cnt < CD - 1) begin
            m_cnt++;
        end else begin
            m_cnt = 0;
            if (m_phase == 0) begin
                m_srclr = 1'b1; m_phase = 1;
            end else if (m_phase == 1) begin
                if (enable) begin take_snap(); m_idx = 3'd0; m_pos = 0; m_phase = 2; end
            end else begin
                d = m_pos / 34;
                q = m_pos % 34;
                if (q < 32) begin
                    if (q % 2 == 0) begin
                        m_sclk = 1'b0;
                        wa = mword(d, 1'b0, 1'b1);
                        wb = mword(d, 1'b1, 1'b0);
                        m_sda = wa[q/2];
                        m_sdb = wb[q/2];
                    end else begin
                        m_sclk = 1'b1;
                    end
                end else if (q == 32) begin
                    m_sclk = 1'b0; m_rclk = 1'b1;
                end else begin
                    m_rclk = 1'b0;
                    m_idx = 3'((d + 1) % N);
                    if (d == N - 1) begin
                        m_fd = 1'b1;
                        if (enable) take_snap();
                        else m_phase = 1;
                    end
                end
                m_pos = (m_pos + 1) % FT;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("outputs_a", {24'd0, sclk_a, sdata_a, rclk_a, srclr_a, idx_a, fd_a},
                               {24'd0, m_sclk, m_sda, m_rclk, m_srclr, m_idx, m_fd});
            check("outputs_b", {24'd0, sclk_b, sdata_b, rclk_b, srclr_b, idx_b, fd_b},
                               {24'd0, m_sclk, m_sdb, m_rclk, m_srclr, m_idx, m_fd});
        end
    end

    // ---------------- serial word capture (acts like the 595 pair) ----------------
    logic [15:0] sh_a = '0, sh_b = '0;
    logic [15:0] cap_a [8];
    logic [15:0] cap_b [8];
    logic p_sclk = 1'b0, p_rclk = 1'b0;
    int rw = 0, rclk_w = 0, latch_cnt = 0;
    logic [2:0] last_latch_idx = 3'd0;

    always @(negedge clk) begin
        if (sclk_a && !p_sclk) begin
            sh_a = {sdata_a, sh_a[15:1]};
            sh_b = {sdata_b, sh_b[15:1]};
        end
        if (rclk_a && !p_rclk) begin
            cap_a[idx_a] = sh_a;
            cap_b[idx_b] = sh_b;
            last_latch_idx = idx_a;
            latch_cnt++;
        end
        if (rclk_a) rw++;
        else if (p_rclk) begin rclk_w = rw; rw = 0; end
        p_sclk = sclk_a;
        p_rclk = rclk_a;
    end

    // ---------------- bounded waits ----------------
    task automatic wait_fd(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!fd_a && cyc < LIM);
        if (!fd_a) check("timeout_frame_done", 32'd0, 32'd1);
    endtask

    task automatic wait_idx(input logic [2:0] v);
        int n = 0;
        while (idx_a != v && n < LIM) begin @(negedge clk); n++; end
        if (idx_a != v) check("timeout_digit_idx", 32'(idx_a), 32'(v));
    endtask

    task automatic wait_sclk_rise();
        int n = 0;
        while (sclk_a && n < LIM) begin @(negedge clk); n++; end
        while (!sclk_a && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) check("timeout_sclk_rise", 32'd0, 32'd1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int cyc, lc;
        rst = 1'b1; enable = 1'b1;
        digit_data = 16'h1234; dp_in = '0; blank_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {26'd0, sclk_a, sdata_a, rclk_a, srclr_a, fd_a, |idx_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("srclr_before_tick", 32'(srclr_a), 32'd0);
        cyc = 1;
        while (!sclk_a && cyc < 100) begin @(negedge clk); cyc++; end
        check("first_sclk_within_4_ticks", 32'(cyc <= 4 * CD), 32'd1);

        wait_fd(cyc);
        check("word_d0_1234", 32'(cap_a[0]), 32'h66FE);
        check("word_d1_1234", 32'(cap_a[1]), 32'h4FFD);
        check("word_d2_1234", 32'(cap_a[2]), 32'h5BFB);
        check("word_d3_1234", 32'(cap_a[3]), 32'h06F7);
        check("word_b_d0_1234", 32'(cap_b[0]), 32'h9901);
        check("word_b_d3_1234", 32'(cap_b[3]), 32'hF908);
        check("rclk_width", 32'(rclk_w), 32'(CD));
        wait_fd(cyc);
        check("frame_period", 32'(cyc), 32'(N * 34 * CD));

        wait_idx(3'd2);
        repeat (34) @(negedge clk);
        digit_data = 16'hABCD;
        wait_fd(cyc);
        check("midframe_d2_old", 32'(cap_a[2]), 32'h5BFB);
        check("midframe_d3_old", 32'(cap_a[3]), 32'h06F7);
        wait_fd(cyc);
        check("next_frame_d0_D", 32'(cap_a[0]), 32'h5EFE);
        check("next_frame_d1_C", 32'(cap_a[1]), 32'h39FD);

        blank_in = 4'b0010; dp_in = 4'b0001; digit_data = 16'h0008;
        wait_fd(cyc);
        wait_fd(cyc);
        check("blank_d1", 32'(cap_a[1]), 32'h00FD);
        check("dp_d0", 32'(cap_a[0]), 32'hFFFE);
        check("blank_d1_seg_al", 32'(cap_b[1]), 32'hFF02);

        blank_in = '0; dp_in = '0; digit_data = 16'h0070;
        wait_fd(cyc);
        wait_fd(cyc);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lz_d3", 32'(cap_a[3][15:8]), 32'h00);
        check("lz_d2", 32'(cap_a[2][15:8]), 32'h00);
`else
        check("lz_d3", 32'(cap_a[3][15:8]), 32'h3F);
        check("lz_d2", 32'(cap_a[2][15:8]), 32'h3F);
`endif
        check("lz_d1", 32'(cap_a[1][15:8]), 32'h07);
        check("lz_d0", 32'(cap_a[0][15:8]), 32'h3F);

        wait_idx(3'd2);
        repeat (7) wait_sclk_rise();
        cyc = 0;
        while (sclk_a && cyc < 100) begin @(negedge clk); cyc++; end
        rst = 1'b1;
        @(negedge clk);
        check("midscan_reset", {26'd0, sclk_a, sdata_a, rclk_a, srclr_a, fd_a, |idx_a}, 32'd0);
        rst = 1'b0;
        lc = latch_cnt;
        cyc = 0;
        while (latch_cnt == lc && cyc < LIM) begin @(negedge clk); cyc++; end
        check("restart_first_digit", 32'(last_latch_idx), 32'd0);
        check("restart_word_d0", 32'(cap_a[0]), 32'h3FFE);

        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(10, 200)) @(negedge clk);
            digit_data = 16'($urandom);
            dp_in      = 4'($urandom);
            blank_in   = 4'($urandom);
            enable     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        enable = 1'b1;
        repeat (2 * FT * CD) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
